// File: rtl/ring_txn_ctrl_if.sv
// ring_txn_ctrl_if
//   Groups the SPI frame-boundary / header inputs and the ring-buffer
//   transaction outputs of ring_txn_ctrl into one bundle.
//   master : the SPI front end (drives frame events and header fields)
//   slave  : ring_txn_ctrl (drives open/commit/rollback pulses and status)
//   Signals:
//     frameStart, inAddr[7:0], inCmdCode[7:0], frameEnd, frameError  (to slave)
//     open[3:0], commit[3:0], rollback[3:0], busy, activeCh[1:0],
//     rollbackCount[7:0]                                             (from slave)
interface ring_txn_ctrl_if;
    logic       frameStart;
    logic [7:0] inAddr;
    logic [7:0] inCmdCode;
    logic       frameEnd;
    logic       frameError;
    logic [3:0] open;
    logic [3:0] commit;
    logic [3:0] rollback;
    logic       busy;
    logic [1:0] activeCh;
    logic [7:0] rollbackCount;

    modport master (
        output frameStart, inAddr, inCmdCode, frameEnd, frameError,
        input  open, commit, rollback, busy, activeCh, rollbackCount
    );

    modport slave (
        input  frameStart, inAddr, inCmdCode, frameEnd, frameError,
        output open, commit, rollback, busy, activeCh, rollbackCount
    );
endinterface

// File: rtl/ring_txn_ctrl.sv
// ring_txn_ctrl
//   Transaction sequencer for the four SPI ring buffers (bit0 MS0, bit1 SM0,
//   bit2 MS1, bit3 SM1). A data frame opens its buffer; a clean frameEnd
//   commits it; frameError, an overlapping frameStart or a timeout rolls it
//   back so partial packets never reach the far side.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset (no rollback is emitted on reset)
//     bus    ring_txn_ctrl_if.slave: frame events in, registered pulses out
//   Build option:
//     TXN_TIMEOUT_EN  when defined, an ACTIVE transaction is rolled back after
//                     TIMEOUT cycles; when undefined there is no counter and
//                     TIMEOUT is ignored.
//   CMD_SEND_DATA / CMD_RECEIVE_DATA carry the ServiceProtocol TCC_SEND_DATA /
//   TCC_RECEIVE_DATA codes.
module ring_txn_ctrl #(
    parameter logic [7:0] ADDR0            = 8'hAB,
    parameter logic [7:0] ADDR1            = 8'hAC,
    parameter int         TIMEOUT          = 65535,
    parameter logic [7:0] CMD_SEND_DATA    = 8'h11,
    parameter logic [7:0] CMD_RECEIVE_DATA = 8'h12
) (
    input  logic            clk,
    input  logic            rst_n,
    ring_txn_ctrl_if.slave  bus
);

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("ring_txn_ctrl: TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] open_q, open_d;
    logic [3:0] commit_q, commit_d;
    logic [3:0] rollback_q, rollback_d;
    logic       busy_q, busy_d;
    logic [7:0] rb_cnt_q, rb_cnt_d;

    // Header decode: which buffer (if any) this frame targets.
    logic       is_data;
    logic [1:0] dec_ch;

    always_comb begin
        is_data = 1'b1;
        dec_ch  = 2'd0;
        if      (bus.inAddr == ADDR0 && bus.inCmdCode == CMD_RECEIVE_DATA) dec_ch = 2'd0;
        else if (bus.inAddr == ADDR0 && bus.inCmdCode == CMD_SEND_DATA)    dec_ch = 2'd1;
        else if (bus.inAddr == ADDR1 && bus.inCmdCode == CMD_RECEIVE_DATA) dec_ch = 2'd2;
        else if (bus.inAddr == ADDR1 && bus.inCmdCode == CMD_SEND_DATA)    dec_ch = 2'd3;
        else                                                               is_data = 1'b0;
    end

    logic timeout_hit;

`ifdef TXN_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // Counts only while a transaction stays ACTIVE, so it restarts at zero on
    // every open and never runs past TIMEOUT-1.
    assign cnt_d = (state_q == S_ACTIVE && state_d == S_ACTIVE) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        open_d     = '0;
        commit_d   = '0;
        rollback_d = '0;
        rb_cnt_d   = rb_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.frameStart && is_data) begin
                    state_d        = S_ACTIVE;
                    ch_d           = dec_ch;
                    open_d[dec_ch] = 1'b1;
                end
            end
            S_ACTIVE: begin
                // Error, an overlapping header and timeout all abandon the
                // frame; they outrank frameEnd so end+error rolls back.
                if (bus.frameError || bus.frameStart || timeout_hit) begin
                    state_d          = S_DONE;
                    rollback_d[ch_q] = 1'b1;
                    if (rb_cnt_q != 8'hFF) rb_cnt_d = rb_cnt_q + 8'd1;
                end else if (bus.frameEnd) begin
                    state_d        = S_DONE;
                    commit_d[ch_q] = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ch_q       <= 2'd0;
            open_q     <= '0;
            commit_q   <= '0;
            rollback_q <= '0;
            busy_q     <= 1'b0;
            rb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            open_q     <= open_d;
            commit_q   <= commit_d;
            rollback_q <= rollback_d;
            busy_q     <= busy_d;
            rb_cnt_q   <= rb_cnt_d;
        end
    end

    assign bus.open          = open_q;
    assign bus.commit        = commit_q;
    assign bus.rollback      = rollback_q;
    assign bus.busy          = busy_q;
    assign bus.activeCh      = ch_q;
    assign bus.rollbackCount = rb_cnt_q;

endmodule

// File: tb/tb_ring_txn_ctrl.sv
// tb_ring_txn_ctrl
//   Self-checking bench for ring_txn_ctrl. A transaction-level reference model
//   (owner buffer, frame age, one dead cycle after each close) predicts every
//   registered output one cycle ahead; directed scenarios are followed by
//   random frame traffic and a rollback-counter saturation run.
module tb_ring_txn_ctrl;

    localparam logic [7:0] A0      = 8'hAB;
    localparam logic [7:0] A1      = 8'hAC;
    localparam logic [7:0] SEND    = 8'h11;
    localparam logic [7:0] RECV    = 8'h12;
    localparam logic [7:0] STS     = 8'h13;
    localparam logic [7:0] RST_CMD = 8'h14;
    localparam int         TO      = 8;
`ifdef TXN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    // Frame length for the first directed commit, kept below the timeout.
    localparam int GAP1 = TO_EN ? 5 : 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ring_txn_ctrl_if bus ();

    ring_txn_ctrl #(
        .ADDR0            (A0),
        .ADDR1            (A1),
        .TIMEOUT          (TO),
        .CMD_SEND_DATA    (SEND),
        .CMD_RECEIVE_DATA (RECV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state and predicted outputs.
    int         m_owner = -1;   // buffer currently open, -1 when none
    int         m_age   = 0;    // cycles spent open without a closing event
    bit         m_done  = 1'b0; // the dead cycle after a close
    int         m_rbc   = 0;
    logic [3:0] e_open, e_commit, e_rollback;
    logic       e_busy;
    logic [1:0] e_ch;

    function automatic int chan_of(logic [7:0] a, logic [7:0] c);
        if (a == A0 && c == RECV) return 0;
        if (a == A0 && c == SEND) return 1;
        if (a == A1 && c == RECV) return 2;
        if (a == A1 && c == SEND) return 3;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner    = -1;
        m_age      = 0;
        m_done     = 1'b0;
        m_rbc      = 0;
        e_open     = '0;
        e_commit   = '0;
        e_rollback = '0;
        e_busy     = 1'b0;
        e_ch       = 2'd0;
    endtask

    task automatic model_step(bit fs, logic [7:0] a, logic [7:0] c, bit fe, bit fer);
        int ch;
        bit kill;
        e_open     = '0;
        e_commit   = '0;
        e_rollback = '0;
        if (m_done) begin
            m_done = 1'b0;
            e_busy = 1'b0;
        end else if (m_owner < 0) begin
            ch = chan_of(a, c);
            if (fs && ch >= 0) begin
                m_owner    = ch;
                m_age      = 0;
                e_open[ch] = 1'b1;
                e_busy     = 1'b1;
                e_ch       = ch[1:0];
            end
        end else begin
            kill = fer || fs || (TO_EN && m_age == TO - 1);
            if (kill || fe) begin
                if (kill) begin
                    e_rollback[m_owner] = 1'b1;
                    if (m_rbc < 255) m_rbc++;
                end else begin
                    e_commit[m_owner] = 1'b1;
                end
                m_owner = -1;
                m_done  = 1'b1;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".open"},          32'(bus.open),          32'(e_open));
        check({tag, ".commit"},        32'(bus.commit),        32'(e_commit));
        check({tag, ".rollback"},      32'(bus.rollback),      32'(e_rollback));
        check({tag, ".busy"},          32'(bus.busy),          32'(e_busy));
        check({tag, ".activeCh"},      32'(bus.activeCh),      32'(e_ch));
        check({tag, ".rollbackCount"}, 32'(bus.rollbackCount), 32'(m_rbc));
    endtask

    // One clock: drive inputs, predict, clock, sample 1 time unit later.
    task automatic tick(string tag, bit fs, logic [7:0] a, logic [7:0] c, bit fe, bit fer);
        bus.frameStart = fs;
        bus.inAddr     = a;
        bus.inCmdCode  = c;
        bus.frameEnd   = fe;
        bus.frameError = fer;
        model_step(fs, a, c, fe, fer);
        @(posedge clk);
        #1;
        check_all(tag);
        bus.frameStart = 1'b0;
        bus.frameEnd   = 1'b0;
        bus.frameError = 1'b0;
    endtask

    task automatic idle(string tag, int n);
        for (int i = 0; i < n; i++) tick(tag, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    bit         r_fs, r_fe, r_fer;
    logic [7:0] r_a, r_c;

    initial begin
        bus.frameStart = 1'b0;
        bus.inAddr     = 8'h00;
        bus.inCmdCode  = 8'h00;
        bus.frameEnd   = 1'b0;
        bus.frameError = 1'b0;
        model_reset();
        #23;
        check_all("reset");
        rst_n = 1'b1;

        // Clean ADDR0/SEND_DATA frame is committed on buffer SM0.
        idle("pre", 3);
        tick("tp1.start", 1'b1, A0, SEND, 1'b0, 1'b0);
        check("tp1.open", 32'(bus.open), 32'h2);
        idle("tp1.wait", GAP1 - 1);
        tick("tp1.end", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check("tp1.commit", 32'(bus.commit), 32'h2);
        idle("tp1.done", 1);
        check("tp1.busy_low", 32'(bus.busy), 32'h0);
        check("tp1.rbc", 32'(bus.rollbackCount), 32'h0);

        // ADDR1/RECEIVE_DATA frame errored five cycles later.
        tick("tp2.start", 1'b1, A1, RECV, 1'b0, 1'b0);
        check("tp2.open", 32'(bus.open), 32'h4);
        idle("tp2.wait", 4);
        tick("tp2.err", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("tp2.rollback", 32'(bus.rollback), 32'h4);
        check("tp2.rbc", 32'(bus.rollbackCount), 32'h1);
        idle("tp2.done", 1);

        // Non-data headers produce nothing.
        tick("tp3.sts", 1'b1, A0, STS, 1'b0, 1'b0);
        tick("tp3.rst", 1'b1, A0, RST_CMD, 1'b0, 1'b0);
        tick("tp3.adr", 1'b1, 8'h00, SEND, 1'b0, 1'b0);
        check("tp3.busy", 32'(bus.busy), 32'h0);

        // Overlapping header rolls back SM1 once; the new frame is not opened.
        tick("tp4.start", 1'b1, A1, SEND, 1'b0, 1'b0);
        idle("tp4.wait", 2);
        tick("tp4.overlap", 1'b1, A0, RECV, 1'b0, 1'b0);
        check("tp4.rollback", 32'(bus.rollback), 32'h8);
        idle("tp4.done", 2);
        check("tp4.once", 32'(bus.rollback), 32'h0);
        // Coincident end and error: rollback wins.
        tick("tp4b.start", 1'b1, A0, RECV, 1'b0, 1'b0);
        idle("tp4b.wait", 1);
        tick("tp4b.both", 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        check("tp4b.rollback", 32'(bus.rollback), 32'h1);
        check("tp4b.commit", 32'(bus.commit), 32'h0);
        idle("tp4b.done", 1);

        // Timeout: rollback exactly TO cycles after open when enabled,
        // otherwise the frame stays open until frameEnd.
        tick("tp5.start", 1'b1, A0, RECV, 1'b0, 1'b0);
        idle("tp5.wait", TO - 1);
        idle("tp5.edge", 1);
        check("tp5.rollback", 32'(bus.rollback), TO_EN ? 32'h1 : 32'h0);
        idle("tp5.hold", 20);
        check("tp5.busy", 32'(bus.busy), TO_EN ? 32'h0 : 32'h1);
        tick("tp5.end", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle("tp5.done", 2);

        // Random frame traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r_fs = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       r_a = A0;
                1:       r_a = A1;
                2:       r_a = 8'h00;
                default: r_a = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       r_c = SEND;
                1:       r_c = RECV;
                2:       r_c = STS;
                3:       r_c = RST_CMD;
                default: r_c = 8'($urandom);
            endcase
            r_fe  = ($urandom_range(0, 9) == 0);
            r_fer = ($urandom_range(0, 24) == 0);
            tick("rand", r_fs, r_a, r_c, r_fe, r_fer);
        end
        idle("rand.drain", 3);

        // 300 errored frames at minimum spacing: counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            tick("sat.start", 1'b1, A1, RECV, 1'b0, 1'b0);
            tick("sat.err", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            idle("sat.done", 1);
        end
        check("sat.rbc", 32'(bus.rollbackCount), 32'hFF);

        // Asynchronous reset mid-transaction: outputs clear at once, no rollback.
        tick("rst.start", 1'b1, A1, SEND, 1'b0, 1'b0);
        idle("rst.wait", 1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.busy", 32'(bus.busy), 32'h0);
        check("rst.rbc", 32'(bus.rollbackCount), 32'h0);
        check("rst.activeCh", 32'(bus.activeCh), 32'h0);
        check_all("rst.async");
        #2;
        rst_n = 1'b1;
        idle("rst.after", 1);
        check("rst.no_rollback", 32'(bus.rollback), 32'h0);
        tick("rst.err_ignored", 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        tick("rst.reopen", 1'b1, A0, SEND, 1'b0, 1'b0);
        tick("rst.end", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle("rst.done", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
